// File: rtl/move_queue.sv
// move_queue: unpacks packed solver move chunks into a FIFO and
// dispatches them one at a time to move_to_step with start/done.
module move_queue #(
    parameter int CHUNK_MOVES = 50,
    parameter int DEPTH       = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4*CHUNK_MOVES-1:0] moves_in,
    input  logic                     moves_valid,
    output logic                     load_ready,
    input  logic                     run,
    output logic [3:0]               next_move,
    output logic                     move_start,
    input  logic                     move_done,
    output logic [7:0]               num_moves,
    output logic [7:0]               curr_step,
    output logic                     seq_done,
    output logic                     overflow
);

    localparam int CW     = 4 * CHUNK_MOVES;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = $clog2(CHUNK_MOVES);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHUNK_MOVES - 1);
    localparam logic [CNT_W-1:0]  FIFO_CAP  = CNT_W'(DEPTH);

    localparam logic [0:0] L_IDLE   = 1'b0;
    localparam logic [0:0] L_UNPACK = 1'b1;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_ISSUE = 2'd1;
    localparam logic [1:0] D_WAIT  = 2'd2;

    logic [0:0]        load_state;
    logic [CW-1:0]     chunk_q;
    logic [SLOT_W-1:0] slot_idx;

    logic [1:0]        disp_state;
    logic              done_q;

    logic [3:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic [3:0]        head_code;
    logic              code_ok;
    logic              unpacking;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              done_rise;
    logic              all_idle;

    // The slot under examination is always the top nibble; the
    // register shifts left one slot per cycle, so slot 49 goes first.
    assign head_code  = chunk_q[CW-1 -: 4];
    assign code_ok    = (head_code >= 4'd2) && (head_code <= 4'd13);
    assign unpacking  = (load_state == L_UNPACK);
    assign fifo_full  = (fifo_count == FIFO_CAP);
    assign fifo_empty = (fifo_count == '0);
    assign push       = unpacking && code_ok && !fifo_full;
    assign pop        = (disp_state == D_IDLE) && run && !fifo_empty;
    assign done_rise  = move_done && !done_q;

    assign load_ready = (load_state == L_IDLE);
    assign move_start = (disp_state == D_ISSUE);

    assign all_idle = run && fifo_empty && (load_state == L_IDLE)
                      && (disp_state == D_IDLE)
                      && (curr_step == num_moves);

    always_ff @(posedge clock) begin
        if (reset) begin
            load_state <= L_IDLE;
            chunk_q    <= '0;
            slot_idx   <= '0;
        end else if (load_state == L_IDLE) begin
            if (moves_valid) begin
                chunk_q    <= moves_in;
                slot_idx   <= SLOT_LAST;
                load_state <= L_UNPACK;
            end
        end else begin
            chunk_q  <= chunk_q << 4;
            slot_idx <= slot_idx - SLOT_W'(1);
            if (slot_idx == '0) begin
                load_state <= L_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= head_code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_state <= D_IDLE;
            next_move  <= 4'd0;
            curr_step  <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            done_q <= move_done;
            case (disp_state)
                D_IDLE: begin
                    if (pop) begin
                        next_move  <= mem[rd_ptr];
                        disp_state <= D_ISSUE;
                    end
                end
                D_ISSUE: begin
                    disp_state <= D_WAIT;
                end
                D_WAIT: begin
                    if (done_rise) begin
                        disp_state <= D_IDLE;
                        if (curr_step != 8'hFF) begin
                            curr_step <= curr_step + 8'd1;
                        end
                    end
                end
                default: begin
                    disp_state <= D_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            num_moves <= 8'd0;
            overflow  <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            if (push && (num_moves != 8'hFF)) begin
                num_moves <= num_moves + 8'd1;
            end
            if (unpacking && code_ok && fifo_full) begin
                overflow <= 1'b1;
            end
            if (all_idle) begin
                seq_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_queue.sv
// Scoreboard bench for move_queue: chunk-level reference model feeds
// an expected-move queue that a monitor checks on every move_start.
module tb_move_queue;

    localparam int NSLOT = 50;

    logic         clock = 1'b0;
    logic         reset;
    logic [199:0] moves_in;
    logic         moves_valid;
    logic         load_ready;
    logic         run;
    logic [3:0]   next_move;
    logic         move_start;
    logic         move_done;
    logic [7:0]   num_moves;
    logic [7:0]   curr_step;
    logic         seq_done;
    logic         overflow;

    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    assign move_done = resp_done | man_done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_loaded = 0;
    int model_ovf = 0;
    int starts_seen = 0;
    int done_delay = 10;
    bit auto_done = 1'b0;
    int mon_exp;

    always #20 clock = ~clock;

    move_queue dut (
        .clock       (clock),
        .reset       (reset),
        .moves_in    (moves_in),
        .moves_valid (moves_valid),
        .load_ready  (load_ready),
        .run         (run),
        .next_move   (next_move),
        .move_start  (move_start),
        .move_done   (move_done),
        .num_moves   (num_moves),
        .curr_step   (curr_step),
        .seq_done    (seq_done),
        .overflow    (overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every move_start must match the queue head.
    always @(negedge clock) begin
        if (!reset && move_start) begin
            starts_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: next_move=%0d expected none",
                         next_move);
            end else begin
                mon_exp = exp_q.pop_front();
                if (next_move !== 4'(mon_exp)) begin
                    errors++;
                    $display("FAIL move_order: got %0d expected %0d",
                             next_move, mon_exp);
                end
            end
        end
    end

    // Stepper stand-in: one-cycle done pulse done_delay cycles after start.
    initial begin
        forever begin
            @(negedge clock);
            if (move_start && auto_done) begin
                repeat (done_delay) @(posedge clock);
                #1 resp_done = 1'b1;
                @(posedge clock);
                #1 resp_done = 1'b0;
            end
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void model_push(input logic [199:0] c);
        for (int s = NSLOT - 1; s >= 0; s--) begin
            logic [3:0] code;
            code = c[s*4 +: 4];
            if (code >= 4'd2 && code <= 4'd13) begin
                if (exp_q.size() < 128) begin
                    exp_q.push_back(int'(code));
                    model_loaded++;
                end else begin
                    model_ovf = 1;
                end
            end
        end
    endfunction

    function automatic int exp_num();
        return (model_loaded > 255) ? 255 : model_loaded;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        exp_q.delete();
        model_loaded = 0;
        model_ovf = 0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!load_ready && n < 300) begin
            cycles(1);
            n++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: load_ready stayed 0 past 300 cycles", nm);
        end
    endtask

    task automatic send_chunk(input logic [199:0] c, output int low);
        wait_ready("send_wait");
        moves_in = c;
        moves_valid = 1'b1;
        cycles(1);
        moves_valid = 1'b0;
        model_push(c);
        low = 0;
        while (!load_ready && low < 300) begin
            cycles(1);
            low++;
        end
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!move_start && n < 200) begin
            cycles(1);
            n++;
        end
        if (!move_start) begin
            checks++;
            errors++;
            $display("FAIL %s: no move_start within 200 cycles", nm);
        end
    endtask

    task automatic drain(input string nm, input int max);
        int n = 0;
        while (!(exp_q.size() == 0 && curr_step == 8'(exp_num()))
               && n < max) begin
            cycles(1);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, curr_step=%0d expected %0d",
                     nm, curr_step, exp_num());
        end
        cycles(2);
    endtask

    function automatic logic [199:0] rand_chunk();
        logic [199:0] c = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                c[s*4 +: 4] = 4'($urandom_range(0, 15));
            end
        end
        return c;
    endfunction

    initial begin
        logic [199:0] c;
        logic [199:0] c2;
        int low;
        int s0;

        reset = 1'b1;
        moves_in = '0;
        moves_valid = 1'b0;
        run = 1'b0;
        cycles(2);
        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_move_start", 32'(move_start), 0);
        chk("rst_next_move", 32'(next_move), 0);
        chk("rst_num_moves", 32'(num_moves), 0);
        chk("rst_curr_step", 32'(curr_step), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;

        // R, Ri, U in the three lowest slots
        do_reset();
        auto_done = 1'b1;
        done_delay = 10;
        c = '0;
        c[11:8] = 4'd2;
        c[7:4] = 4'd3;
        c[3:0] = 4'd4;
        s0 = starts_seen;
        send_chunk(c, low);
        chk("t1_busy_cycles", 32'(low), 50);
        chk("t1_num_moves", 32'(num_moves), 3);
        run = 1'b1;
        drain("t1", 2000);
        chk("t1_starts", 32'(starts_seen - s0), 3);
        chk("t1_curr_step", 32'(curr_step), 3);
        chk("t1_seq_done", 32'(seq_done), 1);
        run = 1'b0;

        // invalid codes scattered around a single valid 12
        do_reset();
        c = '0;
        c[40*4 +: 4] = 4'd1;
        c[30*4 +: 4] = 4'd14;
        c[20*4 +: 4] = 4'd15;
        c[10*4 +: 4] = 4'd12;
        c[3*4 +: 4] = 4'd1;
        send_chunk(c, low);
        chk("t2_num_moves", 32'(num_moves), 1);
        chk("t2_overflow", 32'(overflow), 0);
        run = 1'b1;
        drain("t2", 1000);
        chk("t2_curr_step", 32'(curr_step), 1);
        run = 1'b0;

        // overflow: 150 valid moves into a 128-deep FIFO
        do_reset();
        c = {50{4'h6}};
        for (int k = 0; k < 3; k++) send_chunk(c, low);
        chk("t3_num_moves", 32'(num_moves), 32'(exp_num()));
        chk("t3_num_moves_abs", 32'(num_moves), 128);
        chk("t3_overflow", 32'(overflow), 32'(model_ovf));
        done_delay = 2;
        s0 = starts_seen;
        run = 1'b1;
        drain("t3", 4000);
        chk("t3_starts", 32'(starts_seen - s0), 128);
        chk("t3_curr_step", 32'(curr_step), 128);
        chk("t3_seq_done", 32'(seq_done), 1);
        run = 1'b0;

        // second moves_valid 5 cycles into an unpack is ignored
        do_reset();
        done_delay = 3;
        c = '0;
        c[49*4 +: 4] = 4'd2;
        c[48*4 +: 4] = 4'd7;
        c[30*4 +: 4] = 4'd9;
        c[5*4 +: 4] = 4'd13;
        c[0*4 +: 4] = 4'd5;
        c2 = {50{4'h8}};
        moves_in = c;
        moves_valid = 1'b1;
        cycles(1);
        moves_valid = 1'b0;
        model_push(c);
        cycles(4);
        moves_in = c2;
        moves_valid = 1'b1;
        cycles(1);
        moves_valid = 1'b0;
        wait_ready("t4_wait");
        cycles(2);
        chk("t4_num_moves", 32'(num_moves), 5);
        run = 1'b1;
        drain("t4", 1000);
        chk("t4_curr_step", 32'(curr_step), 5);
        run = 1'b0;

        // move_done high across D_ISSUE counts only on a later rise
        do_reset();
        auto_done = 1'b0;
        man_done = 1'b1;
        c = '0;
        c[3:0] = 4'd13;
        send_chunk(c, low);
        run = 1'b1;
        wait_start("t5_start");
        cycles(4);
        chk("t5_held_high", 32'(curr_step), 0);
        man_done = 1'b0;
        cycles(3);
        chk("t5_low", 32'(curr_step), 0);
        man_done = 1'b1;
        cycles(3);
        chk("t5_rise", 32'(curr_step), 1);
        chk("t5_seq_done", 32'(seq_done), 1);
        man_done = 1'b0;
        run = 1'b0;

        // reset while waiting on the first of four moves
        do_reset();
        c = '0;
        c[15:12] = 4'd8;
        c[11:8] = 4'd9;
        c[7:4] = 4'd10;
        c[3:0] = 4'd11;
        send_chunk(c, low);
        run = 1'b1;
        wait_start("t6_start");
        cycles(3);
        s0 = starts_seen;
        do_reset();
        chk("t6_num_moves", 32'(num_moves), 0);
        chk("t6_curr_step", 32'(curr_step), 0);
        chk("t6_load_ready", 32'(load_ready), 1);
        chk("t6_next_move", 32'(next_move), 0);
        chk("t6_seq_done_now", 32'(seq_done), 0);
        cycles(30);
        chk("t6_no_starts", 32'(starts_seen - s0), 0);
        chk("t6_seq_done_empty", 32'(seq_done), 1);
        run = 1'b0;

        // random chunks loaded while dispatch runs
        do_reset();
        auto_done = 1'b1;
        done_delay = 4;
        send_chunk(rand_chunk(), low);
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            done_delay = $urandom_range(1, 6);
            send_chunk(rand_chunk(), low);
            chk("t7_busy_cycles", 32'(low), 50);
        end
        drain("t7", 6000);
        chk("t7_num_moves", 32'(num_moves), 32'(exp_num()));
        chk("t7_curr_step", 32'(curr_step), 32'(exp_num()));
        chk("t7_overflow", 32'(overflow), 0);
        chk("t7_seq_done", 32'(seq_done), 1);
        run = 1'b0;
        auto_done = 1'b0;

        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
